apb_rx_fifo_slave: RTL

//  APB register slave for the UART receiver, with a DEPTH-entry RX FIFO in place of the single data buffer.

---
 rtl/apb_rx_fifo_slave.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_rx_fifo_slave.sv
// apb_rx_fifo_slave: APB register slave for the UART receiver.
// Holds received words in a DEPTH-entry FIFO, keeps sticky W1C error flags,
// and drives the receiver's bit period and data size. The interrupt is registered.
module apb_rx_fifo_slave #(
  parameter int DEPTH     = 8,
  parameter int BP_W      = 14,
  parameter int RST_BP    = 10,
  parameter int RST_DSIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            data_ready,
  input  logic            overrun_error,
  input  logic            framing_error,
  output logic            data_read,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [2:0]      paddr,
  input  logic [7:0]      pwdata,
  output logic [7:0]      prdata,
  output logic            pslverr,
  output logic [BP_W-1:0] bit_period,
  output logic [3:0]      data_size,
  output logic            irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [BP_W-1:0] BP_RST   = BP_W'(RST_BP);
  localparam logic [3:0]      DS_RST   = 4'(RST_DSIZE);

  // Storage and control state
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      err_q, err_d;        // {fifo_ovf, overrun, framing}
  logic [1:0]      irq_en_q, irq_en_d;
  logic [BP_W-1:0] bp_q, bp_d;
  logic [3:0]      dsize_q, dsize_d;
  logic [7:0]      prdata_q, prdata_d;
  logic            irq_q, irq_d;
  logic            dr_q, dr_d;
  logic            data_read_q, data_read_d;

  // Decoded strobes
  logic            setup_s, access_s, wr_s, rd_s;
  logic            empty_s, full_s;
  logic            push_s, pop_s, push_ok_s, ovf_s;
  logic [2:0]      w1c_s;
  logic [7:0]      rd_val_s;
  logic [15:0]     bp_ext_s;

  // Bus phase, FIFO level and push/pop qualification
  always_comb begin
    setup_s   = psel & ~penable;
    access_s  = psel & penable;
    wr_s      = access_s & pwrite;
    rd_s      = access_s & ~pwrite;
    empty_s   = (count_q == {CW{1'b0}});
    full_s    = (count_q == FULL_CNT);
    push_s    = data_ready & ~dr_q;
    pop_s     = rd_s & (paddr == 3'h6) & ~empty_s;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    push_ok_s = push_s & (~full_s | pop_s);
    ovf_s     = push_s & ~push_ok_s;
    if (wr_s && (paddr == 3'h1)) begin
      w1c_s = pwdata[2:0];
    end else begin
      w1c_s = 3'b000;
    end
  end

  // Read mux of the addressed register, sampled into prdata at setup
  always_comb begin
    bp_ext_s = 16'(bp_q);
    rd_val_s = 8'h00;
    case (paddr)
      3'h0:    rd_val_s = {6'b000000, full_s, ~empty_s};
      3'h1:    rd_val_s = {5'b00000, err_q};
      3'h2:    rd_val_s = bp_ext_s[7:0];
      3'h3:    rd_val_s = bp_ext_s[15:8];
      3'h4:    rd_val_s = {4'b0000, dsize_q};
      3'h5:    rd_val_s = 8'(count_q);
      3'h6: begin
        if (empty_s) begin
          rd_val_s = 8'h00;
        end else begin
          rd_val_s = mem_q[rd_ptr_q];
        end
      end
      3'h7:    rd_val_s = {6'b000000, irq_en_q};
      default: rd_val_s = 8'h00;
    endcase
  end

  // Error response: illegal writes, or popping an empty FIFO
  always_comb begin
    if (access_s) begin
      if (pwrite) begin
        pslverr = (paddr == 3'h0) | (paddr == 3'h5) | (paddr == 3'h6);
      end else begin
        pslverr = (paddr == 3'h6) & empty_s;
      end
    end else begin
      pslverr = 1'b0;
    end
  end

  // Next-state computation for FIFO, registers, status and outputs
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    irq_en_d    = irq_en_q;
    bp_d        = bp_q;
    dsize_d     = dsize_q;

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr_s) begin
      case (paddr)
        3'h2:    bp_d[7:0]      = pwdata;
        3'h3:    bp_d[BP_W-1:8] = pwdata[BP_W-9:0];
        3'h4:    dsize_d        = pwdata[3:0];
        3'h7:    irq_en_d       = pwdata[1:0];
        default: bp_d           = bp_q;
      endcase
    end else begin
      bp_d = bp_q;
    end

    // New events win over a same-cycle clear
    err_d       = (err_q & ~w1c_s) | {ovf_s, overrun_error, framing_error};
    prdata_d    = setup_s ? rd_val_s : 8'h00;
    irq_d       = (irq_en_q[0] & ~empty_s) | (irq_en_q[1] & (|err_q));
    dr_d        = data_ready;
    data_read_d = push_s;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      err_q       <= 3'b000;
      irq_en_q    <= 2'b00;
      bp_q        <= BP_RST;
      dsize_q     <= DS_RST;
      prdata_q    <= 8'h00;
      irq_q       <= 1'b0;
      dr_q        <= 1'b0;
      data_read_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      bp_q        <= bp_d;
      dsize_q     <= dsize_d;
      prdata_q    <= prdata_d;
      irq_q       <= irq_d;
      dr_q        <= dr_d;
      data_read_q <= data_read_d;
    end
  end

  assign prdata     = prdata_q;
  assign bit_period = bp_q;
  assign data_size  = dsize_q;
  assign irq        = irq_q;
  assign data_read  = data_read_q;

endmodule
